fp_mul_arbiter: RTL and testbench

//  Shares one fp_mul datapath (X*Y -> Z, ovrf/udrf, r_mode) among NREQ requesters.
//  - Picks one requester per cycle, round-robin, and registers its operands into the multiplier.
//  - Tracks each operation's owner through the multiplier's LAT pipeline stages.
//  - Stores each result in that requester's response buffer.
//  - Keeps a wrapping op counter and sticky ovrf/udrf status for the FPU control/status logic.

---
 rtl/fp_mul_arbiter.sv | 135 +++++++++++++
 tb/tb_fp_mul_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// Round-robin front end sharing one pipelined fp_mul among NREQ requesters.
// Each requester owns one outstanding op; results land in per-requester buffers.
module fp_mul_arbiter #(
    parameter int NREQ = 2,
    parameter int LAT  = 2,
    parameter int TW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_x,
    input  logic [NREQ*32-1:0] req_y,
    input  logic [NREQ*3-1:0] req_rmode,
    output logic              mul_valid,
    output logic [31:0]       mul_X,
    output logic [31:0]       mul_Y,
    output logic [2:0]        mul_rmode,
    input  logic [31:0]       mul_Z,
    input  logic              mul_ovrf,
    input  logic              mul_udrf,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [NREQ*32-1:0] rsp_z,
    output logic [NREQ*2-1:0] rsp_flags,
    output logic [31:0]       op_cnt,
    output logic              ovrf_stk,
    output logic              udrf_stk,
    input  logic              stk_clr,
    output logic              idle
);

    logic [NREQ-1:0][31:0] x_v;
    logic [NREQ-1:0][31:0] y_v;
    logic [NREQ-1:0][2:0]  rm_v;
    logic [NREQ-1:0][31:0] z_q;
    logic [NREQ-1:0][1:0]  f_q;

    logic [TW-1:0]   rr_ptr;
    logic [TW-1:0]   gnt_idx;
    logic [TW-1:0]   nxt_ptr;
    logic [NREQ-1:0] busy;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rsp_fire;
    logic            gnt_any;

    logic [LAT:0]         pv;
    logic [LAT:0][TW-1:0] pt;
    logic                 cap;
    logic [TW-1:0]        cap_tag;

    assign x_v       = req_x;
    assign y_v       = req_y;
    assign rm_v      = req_rmode;
    assign rsp_z     = z_q;
    assign rsp_flags = f_q;

    assign elig      = req_valid & ~busy;
    assign rsp_fire  = rsp_valid & rsp_ready;
    assign req_ready = gnt;
    assign cap       = pv[LAT];
    assign cap_tag   = pt[LAT];
    assign idle      = ~|busy;

    // Search starts at rr_ptr and wraps modulo NREQ.
    always_comb begin
        logic [TW:0]   sum;
        logic [TW-1:0] idx;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        nxt_ptr = rr_ptr;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (TW+1)'(k);
            if (sum >= (TW+1)'(NREQ))
                sum = sum - (TW+1)'(NREQ);
            idx = sum[TW-1:0];
            if (!gnt_any && elig[idx] && !rst) begin
                gnt[idx] = 1'b1;
                gnt_any  = 1'b1;
                gnt_idx  = idx;
                nxt_ptr  = (idx == TW'(NREQ-1)) ? '0
                                                : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            busy      <= '0;
            mul_valid <= 1'b0;
            mul_X     <= '0;
            mul_Y     <= '0;
            mul_rmode <= '0;
            pv        <= '0;
            pt        <= '0;
            rsp_valid <= '0;
            z_q       <= '0;
            f_q       <= '0;
            op_cnt    <= '0;
            ovrf_stk  <= 1'b0;
            udrf_stk  <= 1'b0;
        end else begin
            mul_valid <= gnt_any;
            if (gnt_any) begin
                rr_ptr    <= nxt_ptr;
                mul_X     <= x_v[gnt_idx];
                mul_Y     <= y_v[gnt_idx];
                mul_rmode <= rm_v[gnt_idx];
                op_cnt    <= op_cnt + 32'd1;
            end
            pv[0] <= gnt_any;
            pt[0] <= gnt_idx;
            for (int k = 1; k <= LAT; k++) begin
                pv[k] <= pv[k-1];
                pt[k] <= pt[k-1];
            end
            busy      <= (busy | gnt) & ~rsp_fire;
            rsp_valid <= rsp_valid & ~rsp_fire;
            // Capture never hits an index being consumed this edge.
            if (cap) begin
                rsp_valid[cap_tag] <= 1'b1;
                z_q[cap_tag]       <= mul_Z;
                f_q[cap_tag]       <= {mul_ovrf, mul_udrf};
            end
            ovrf_stk <= (ovrf_stk & ~stk_clr) | (cap & mul_ovrf);
            udrf_stk <= (udrf_stk & ~stk_clr) | (cap & mul_udrf);
        end
    end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: a stand-in pipelined multiplier plus
// a timestamp-based reference model of grants, results and status.
module tb_fp_mul_arbiter;

    localparam int NREQ = 2;
    localparam int LAT  = 2;
    localparam int TW   = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_x;
    logic [NREQ*32-1:0]   req_y;
    logic [NREQ*3-1:0]    req_rmode;
    logic                 mul_valid;
    logic [31:0]          mul_X;
    logic [31:0]          mul_Y;
    logic [2:0]           mul_rmode;
    logic [31:0]          mul_Z;
    logic                 mul_ovrf;
    logic                 mul_udrf;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [NREQ*32-1:0]   rsp_z;
    logic [NREQ*2-1:0]    rsp_flags;
    logic [31:0]          op_cnt;
    logic                 ovrf_stk;
    logic                 udrf_stk;
    logic                 stk_clr;
    logic                 idle;

    fp_mul_arbiter #(.NREQ(NREQ), .LAT(LAT), .TW(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_rmode(req_rmode),
        .mul_valid(mul_valid), .mul_X(mul_X), .mul_Y(mul_Y),
        .mul_rmode(mul_rmode), .mul_Z(mul_Z),
        .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_flags(rsp_flags),
        .op_cnt(op_cnt), .ovrf_stk(ovrf_stk), .udrf_stk(udrf_stk),
        .stk_clr(stk_clr), .idle(idle)
    );

    always #5 clk = ~clk;

    // Truncating single-precision multiply; returns {ovrf,udrf,z}.
    function automatic logic [33:0] fmul(input logic [31:0] a,
                                         input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] m;
        logic [22:0] f;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
            return {2'b00, s, 31'd0};
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            f = m[46:24];
            e = e + 1;
        end else begin
            f = m[45:23];
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (e <= 0)   return {2'b01, s, 31'd0};
        return {2'b00, s, e[7:0], f};
    endfunction

    logic [33:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= fmul(mul_X, mul_Y);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign {mul_ovrf, mul_udrf, mul_Z} = mpipe[LAT-1];

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        total++;
        assert (o === e) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, o, e);
        end
    endtask

    typedef struct {
        int          cap;
        int          idx;
        logic [33:0] r;
    } pend_t;

    pend_t           pq[$];
    int              cyc;
    int              m_ptr;
    logic [NREQ-1:0] m_busy;
    logic [NREQ-1:0] m_rv;
    logic [31:0]     m_rz [NREQ];
    logic [1:0]      m_rf [NREQ];
    logic [31:0]     m_cnt;
    logic            m_ov;
    logic            m_ud;
    logic            m_mv;
    logic [31:0]     m_mx;
    logic [31:0]     m_my;
    logic [2:0]      m_mr;
    int              d_acc [NREQ];

    task automatic m_reset();
        m_ptr  = 0;
        m_busy = '0;
        m_rv   = '0;
        for (int i = 0; i < NREQ; i++) begin
            m_rz[i] = '0;
            m_rf[i] = '0;
        end
        m_cnt = '0;
        m_ov  = 1'b0;
        m_ud  = 1'b0;
        m_mv  = 1'b0;
        m_mx  = '0;
        m_my  = '0;
        m_mr  = '0;
        pq.delete();
    endtask

    // One clock: check outputs, predict the edge, advance.
    task automatic step();
        int              g;
        int              idx;
        logic [NREQ-1:0] er;
        pend_t           keep[$];
        logic            nov;
        logic            nud;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("rsp_valid%0d", i), rsp_valid[i], m_rv[i]);
            if (m_rv[i]) begin
                chk($sformatf("rsp_z%0d", i), rsp_z[32*i+:32], m_rz[i]);
                chk($sformatf("rsp_flags%0d", i),
                    rsp_flags[2*i+:2], m_rf[i]);
            end
        end
        chk("op_cnt", op_cnt, m_cnt);
        chk("ovrf_stk", ovrf_stk, m_ov);
        chk("udrf_stk", udrf_stk, m_ud);
        chk("idle", idle, ~|m_busy);
        chk("mul_valid", mul_valid, m_mv);
        chk("mul_X", mul_X, m_mx);
        chk("mul_Y", mul_Y, m_my);
        chk("mul_rmode", mul_rmode, m_mr);
        g = -1;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[idx] && !m_busy[idx]) g = idx;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        for (int i = 0; i < NREQ; i++) d_acc[i] += int'(req_ready[i]);
        if (rst) begin
            m_reset();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_rv[i] && rsp_ready[i]) begin
                    m_rv[i]   = 1'b0;
                    m_busy[i] = 1'b0;
                end
            end
            nov = 1'b0;
            nud = 1'b0;
            foreach (pq[j]) begin
                if (pq[j].cap == cyc) begin
                    m_rv[pq[j].idx] = 1'b1;
                    m_rz[pq[j].idx] = pq[j].r[31:0];
                    m_rf[pq[j].idx] = pq[j].r[33:32];
                    nov = pq[j].r[33];
                    nud = pq[j].r[32];
                end else begin
                    keep.push_back(pq[j]);
                end
            end
            pq   = keep;
            m_ov = (m_ov & !stk_clr) | nov;
            m_ud = (m_ud & !stk_clr) | nud;
            m_mv = (g >= 0);
            if (g >= 0) begin
                m_busy[g] = 1'b1;
                m_ptr     = (g + 1) % NREQ;
                m_cnt     = m_cnt + 32'd1;
                m_mx      = req_x[32*g+:32];
                m_my      = req_y[32*g+:32];
                m_mr      = req_rmode[3*g+:3];
                pq.push_back('{cyc + 1 + LAT, g,
                               fmul(m_mx, m_my)});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_ops();
        req_x     = {$urandom, $urandom};
        req_y     = {$urandom, $urandom};
        req_rmode = 6'($urandom);
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        repeat (LAT + 4) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        cyc       = 0;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        stk_clr   = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_rmode = '0;
        for (int i = 0; i < NREQ; i++) d_acc[i] = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_idle", idle, 1'b1);
        chk("rst_op_cnt", op_cnt, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);

        // Single op from requester 0: 3.0 * 3.0.
        req_x[31:0]     = 32'h40400000;
        req_y[31:0]     = 32'h40400000;
        req_rmode[2:0]  = 3'b001;
        req_valid       = 2'b01;
        step();
        req_valid = '0;
        chk("t1_mul_valid", mul_valid, 1'b1);
        chk("t1_mul_X", mul_X, 32'h40400000);
        chk("t1_mul_rmode", mul_rmode, 3'b001);
        repeat (LAT) step();
        chk("t1_early", rsp_valid[0], 1'b0);
        step();
        chk("t1_rsp_valid", rsp_valid[0], 1'b1);
        chk("t1_rsp_z", rsp_z[31:0], 32'h41100000);
        chk("t1_flags", rsp_flags[1:0], 2'b00);
        chk("t1_op_cnt", op_cnt, 32'd1);
        drain();

        // Both requesters always valid, always ready.
        do_reset();
        for (int i = 0; i < NREQ; i++) d_acc[i] = 0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        repeat (24) begin
            rand_ops();
            step();
        end
        for (int i = 0; i < NREQ; i++)
            chk($sformatf("t2_acc%0d", i), d_acc[i],
                (24 - i + LAT + 2) / (LAT + 3));
        drain();

        // Overflow from requester 1 and sticky behaviour.
        req_x[63:32] = 32'h7F000000;
        req_y[63:32] = 32'h7F000000;
        rsp_ready    = 2'b00;
        req_valid    = 2'b10;
        step();
        req_valid = '0;
        repeat (LAT + 1) step();
        chk("t3_flags1", rsp_flags[3:2], 2'b10);
        chk("t3_ovrf_stk", ovrf_stk, 1'b1);
        repeat (3) step();
        chk("t3_ovrf_hold", ovrf_stk, 1'b1);
        stk_clr = 1'b1;
        step();
        stk_clr = 1'b0;
        chk("t3_ovrf_clr", ovrf_stk, 1'b0);
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        step();
        req_valid = '0;
        repeat (LAT) step();
        stk_clr = 1'b1;
        step();
        stk_clr = 1'b0;
        chk("t3_clr_vs_set", ovrf_stk, 1'b1);
        drain();

        // Held response on requester 0 while requester 1 keeps going.
        req_x[31:0] = 32'h3FC00000;
        req_y[31:0] = 32'h40000000;
        rsp_ready   = 2'b00;
        req_valid   = 2'b01;
        step();
        req_valid = '0;
        repeat (LAT + 1) step();
        for (int i = 0; i < NREQ; i++) d_acc[i] = 0;
        req_valid = 2'b11;
        rsp_ready = 2'b10;
        for (int n = 0; n < 10; n++) begin
            req_x[63:32] = $urandom;
            req_y[63:32] = $urandom;
            step();
            chk($sformatf("t4_hold_v%0d", n), rsp_valid[0], 1'b1);
            chk($sformatf("t4_hold_z%0d", n), rsp_z[31:0],
                32'h40400000);
        end
        chk("t4_acc0", d_acc[0], 0);
        chk("t4_acc1", d_acc[1], 2);
        drain();

        // Reset while an op is in flight.
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        step();
        req_valid = '0;
        do_reset();
        chk("t5_op_cnt", op_cnt, 32'd0);
        chk("t5_idle", idle, 1'b1);
        repeat (LAT + 4) step();
        chk("t5_no_rsp", rsp_valid, 2'b00);

        // op_cnt wrap.
        force dut.op_cnt = 32'hFFFFFFFF;
        #1;
        release dut.op_cnt;
        m_cnt     = 32'hFFFFFFFF;
        req_valid = 2'b01;
        step();
        req_valid = '0;
        chk("t6_wrap", op_cnt, 32'd0);
        drain();

        // Random traffic against the model.
        repeat (300) begin
            rand_ops();
            req_valid = 2'($urandom);
            for (int i = 0; i < NREQ; i++)
                rsp_ready[i] = ($urandom_range(3) != 0);
            stk_clr = ($urandom_range(9) == 0);
            rst     = ($urandom_range(99) == 0);
            step();
        end
        rst     = 1'b0;
        stk_clr = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
